// File: rtl/exec_core.sv
// exec_core: multi-cycle execution core. It fetches 32-bit instruction words over a shared
// RAM request/ack port, decodes and executes them, and writes a local register file.
// It supports immediate/move/load/store, add/sub, compare and branches, FPU ops through an
// external done-handshaked FPU, setdebug and halt.
// Latency: at least 4 cycles per instruction (FETCH, FWAIT, DECODE, WB) when ack follows
// the request within one cycle. Memory and FPU ops add their wait states.
// Backpressure: RAM requests are level signals held until ram_ack is sampled. FPU ops wait
// indefinitely for fpu_done. Stray ack or done pulses are ignored.
//
// Ports:
//   clk, reset             clock; asynchronous active-high reset
//   ram_rdata/ram_ack      read data and 1-cycle acknowledge from the RAM arbiter
//   ram_addr/ram_wdata     request address and store data
//   ram_rd_req/ram_wr_req  level requests
//   fpu_start/fpu_op       1-cycle launch pulse and operation (0 fadd, 1 fsub, 2 int->float)
//   fpu_a/fpu_b            FPU operands, stable from start until done
//   fpu_result/fpu_done    FPU result and 1-cycle completion
//   ipointer/opcode        instruction pointer and current opcode
//   flags/halted/debug     {N,Z} from last cmp, halt status, last setdebug value
module exec_core #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 16,
    parameter int NREGS    = 16,
    parameter int IP_STEP  = 4,
    parameter int RESET_IP = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_rd_req,
    output logic              ram_wr_req,
    output logic              fpu_start,
    output logic [1:0]        fpu_op,
    output logic [DATA_W-1:0] fpu_a,
    output logic [DATA_W-1:0] fpu_b,
    input  logic [DATA_W-1:0] fpu_result,
    input  logic              fpu_done,
    output logic [ADDR_W-1:0] ipointer,
    output logic [7:0]        opcode,
    output logic [1:0]        flags,
    output logic              halted,
    output logic [DATA_W-1:0] debug
);

    localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [7:0] OP_MOVI = 8'd1;
    localparam logic [7:0] OP_LOAD = 8'd2;
    localparam logic [7:0] OP_MOV  = 8'd3;
    localparam logic [7:0] OP_STOR = 8'd4;
    localparam logic [7:0] OP_ADD  = 8'd10;
    localparam logic [7:0] OP_SUB  = 8'd11;
    localparam logic [7:0] OP_CMP  = 8'd12;
    localparam logic [7:0] OP_JMP  = 8'd13;
    localparam logic [7:0] OP_JZ   = 8'd14;
    localparam logic [7:0] OP_JNZ  = 8'd15;
    localparam logic [7:0] OP_FADD = 8'd20;
    localparam logic [7:0] OP_FSUB = 8'd21;
    localparam logic [7:0] OP_ITOF = 8'd22;
    localparam logic [7:0] OP_DBG  = 8'd30;
    localparam logic [7:0] OP_HALT = 8'd31;

    typedef enum logic [2:0] {
        S_FETCH,
        S_FWAIT,
        S_DECODE,
        S_MWAIT,
        S_FWAIT2,
        S_WB,
        S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ip_q, ip_d;
    logic [7:0]        op_q, op_d;
    logic [IW-1:0]     ridx_q, ridx_d;
    logic [15:0]       k_q, k_d;
    logic [1:0]        flags_q, flags_d;
    logic              halted_q, halted_d;
    logic [DATA_W-1:0] debug_q, debug_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rd_req_q, rd_req_d;
    logic              wr_req_q, wr_req_d;
    logic              fpu_start_q, fpu_start_d;
    logic [1:0]        fpu_op_q, fpu_op_d;
    logic [DATA_W-1:0] fpu_a_q, fpu_a_d;
    logic [DATA_W-1:0] fpu_b_q, fpu_b_d;
    logic [DATA_W-1:0] rval_q, rval_d;
    logic [DATA_W-1:0] sval_q, sval_d;
    logic [DATA_W-1:0] res_q, res_d;

    // Register file has no reset: contents survive a core reset.
    logic [DATA_W-1:0] rf_q [NREGS];
    logic              rf_we;
    logic [DATA_W-1:0] rf_wdata;

    // The instruction word is always 32 bits regardless of DATA_W; the fields not
    // needed for the selected NREGS are folded into a sink so every bit is accounted for.
    logic [31:0]       fetch_word;
    logic              unused_fetch;
    logic [IW-1:0]     sidx;
    logic [DATA_W-1:0] diff;

    assign fetch_word   = 32'(ram_rdata);
    assign unused_fetch = ^fetch_word;
    assign sidx         = k_q[IW-1:0];
    assign diff         = rval_q - sval_q;

    always_comb begin
        state_d     = state_q;
        ip_d        = ip_q;
        op_d        = op_q;
        ridx_d      = ridx_q;
        k_d         = k_q;
        flags_d     = flags_q;
        halted_d    = halted_q;
        debug_d     = debug_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_req_d    = rd_req_q;
        wr_req_d    = wr_req_q;
        fpu_start_d = 1'b0;
        fpu_op_d    = fpu_op_q;
        fpu_a_d     = fpu_a_q;
        fpu_b_d     = fpu_b_q;
        rval_d      = rval_q;
        sval_d      = sval_q;
        res_d       = res_q;
        rf_we       = 1'b0;
        rf_wdata    = '0;

        case (state_q)
            S_FETCH: begin
                rd_req_d = 1'b1;
                addr_d   = ip_q;
                state_d  = S_FWAIT;
            end

            S_FWAIT: begin
                if (ram_ack) begin
                    op_d     = fetch_word[7:0];
                    ridx_d   = fetch_word[8 +: IW];
                    k_d      = fetch_word[31:16];
                    rd_req_d = 1'b0;
                    state_d  = S_DECODE;
                end
            end

            S_DECODE: begin
                // Operands are snapshotted here so R==S aliasing reads one consistent value.
                rval_d  = rf_q[ridx_q];
                sval_d  = rf_q[sidx];
                state_d = S_WB;
                case (op_q)
                    OP_LOAD: begin
                        rd_req_d = 1'b1;
                        addr_d   = k_q[ADDR_W-1:0];
                        state_d  = S_MWAIT;
                    end
                    OP_STOR: begin
                        wr_req_d = 1'b1;
                        addr_d   = k_q[ADDR_W-1:0];
                        wdata_d  = rf_q[ridx_q];
                        state_d  = S_MWAIT;
                    end
                    OP_FADD, OP_FSUB, OP_ITOF: begin
                        fpu_start_d = 1'b1;
                        fpu_op_d    = 2'(op_q - OP_FADD);
                        fpu_a_d     = rf_q[ridx_q];
                        fpu_b_d     = rf_q[sidx];
                        state_d     = S_FWAIT2;
                    end
                    default: ;
                endcase
            end

            S_MWAIT: begin
                if (ram_ack) begin
                    rd_req_d = 1'b0;
                    wr_req_d = 1'b0;
                    res_d    = ram_rdata;
                    state_d  = S_WB;
                end
            end

            S_FWAIT2: begin
                if (fpu_done) begin
                    res_d   = fpu_result;
                    state_d = S_WB;
                end
            end

            S_WB: begin
                ip_d    = ip_q + ADDR_W'(IP_STEP);
                state_d = S_FETCH;
                case (op_q)
                    OP_MOVI: begin
                        rf_we    = 1'b1;
                        rf_wdata = DATA_W'(k_q);
                    end
                    OP_LOAD, OP_FADD, OP_FSUB, OP_ITOF: begin
                        rf_we    = 1'b1;
                        rf_wdata = res_q;
                    end
                    OP_MOV: begin
                        rf_we    = 1'b1;
                        rf_wdata = sval_q;
                    end
                    OP_ADD: begin
                        rf_we    = 1'b1;
                        rf_wdata = rval_q + sval_q;
                    end
                    OP_SUB: begin
                        rf_we    = 1'b1;
                        rf_wdata = diff;
                    end
                    OP_CMP:  flags_d = {diff[DATA_W-1], (rval_q == sval_q)};
                    OP_JMP:  ip_d = k_q[ADDR_W-1:0];
                    OP_JZ:   if (flags_q[0]) ip_d = k_q[ADDR_W-1:0];
                    OP_JNZ:  if (!flags_q[0]) ip_d = k_q[ADDR_W-1:0];
                    OP_DBG:  debug_d = rval_q;
                    OP_HALT: begin
                        ip_d     = ip_q;
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end
                    default: ;
                endcase
            end

            S_HALT: state_d = S_HALT;

            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            ip_q        <= ADDR_W'(RESET_IP);
            op_q        <= '0;
            ridx_q      <= '0;
            k_q         <= '0;
            flags_q     <= '0;
            halted_q    <= 1'b0;
            debug_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_req_q    <= 1'b0;
            wr_req_q    <= 1'b0;
            fpu_start_q <= 1'b0;
            fpu_op_q    <= '0;
            fpu_a_q     <= '0;
            fpu_b_q     <= '0;
            rval_q      <= '0;
            sval_q      <= '0;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            ip_q        <= ip_d;
            op_q        <= op_d;
            ridx_q      <= ridx_d;
            k_q         <= k_d;
            flags_q     <= flags_d;
            halted_q    <= halted_d;
            debug_q     <= debug_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_req_q    <= rd_req_d;
            wr_req_q    <= wr_req_d;
            fpu_start_q <= fpu_start_d;
            fpu_op_q    <= fpu_op_d;
            fpu_a_q     <= fpu_a_d;
            fpu_b_q     <= fpu_b_d;
            rval_q      <= rval_d;
            sval_q      <= sval_d;
            res_q       <= res_d;
        end
    end

    // rf_we is only raised in WB, whose state register is reset asynchronously,
    // so a reset never lets a stale write through.
    always_ff @(posedge clk) begin
        if (rf_we) begin
            rf_q[ridx_q] <= rf_wdata;
        end
    end

    assign ram_addr   = addr_q;
    assign ram_wdata  = wdata_q;
    assign ram_rd_req = rd_req_q;
    assign ram_wr_req = wr_req_q;
    assign fpu_start  = fpu_start_q;
    assign fpu_op     = fpu_op_q;
    assign fpu_a      = fpu_a_q;
    assign fpu_b      = fpu_b_q;
    assign ipointer   = ip_q;
    assign opcode     = op_q;
    assign flags      = flags_q;
    assign halted     = halted_q;
    assign debug      = debug_q;

endmodule

// File: tb/tb_exec_core.sv
module tb_exec_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    always #5 clk = ~clk;

    // Main instance (default parameters)
    logic [31:0] ram_rdata = '0;
    logic        ram_ack = 1'b0;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_rd_req, ram_wr_req;
    logic        fpu_start;
    logic [1:0]  fpu_op;
    logic [31:0] fpu_a, fpu_b;
    logic [31:0] fpu_result = '0;
    logic        fpu_done = 1'b0;
    logic [15:0] ipointer;
    logic [7:0]  opcode;
    logic [1:0]  flags;
    logic        halted;
    logic [31:0] debug;

    exec_core u_dut (
        .clk(clk), .reset(reset),
        .ram_rdata(ram_rdata), .ram_ack(ram_ack), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rd_req(ram_rd_req), .ram_wr_req(ram_wr_req),
        .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
        .fpu_result(fpu_result), .fpu_done(fpu_done),
        .ipointer(ipointer), .opcode(opcode), .flags(flags), .halted(halted), .debug(debug)
    );

    // Narrow-address instance fetching nops from 0xFC to show ip wrap
    logic        w_ack = 1'b0;
    logic [7:0]  w_ram_addr;
    logic [31:0] w_ram_wdata;
    logic        w_rd_req, w_wr_req, w_fpu_start;
    logic [1:0]  w_fpu_op;
    logic [31:0] w_fpu_a, w_fpu_b;
    logic [7:0]  w_ipointer;
    logic [7:0]  w_opcode;
    logic [1:0]  w_flags;
    logic        w_halted;
    logic [31:0] w_debug;

    exec_core #(.ADDR_W(8), .RESET_IP(8'hFC)) u_wrap (
        .clk(clk), .reset(reset),
        .ram_rdata(32'h0), .ram_ack(w_ack), .ram_addr(w_ram_addr), .ram_wdata(w_ram_wdata),
        .ram_rd_req(w_rd_req), .ram_wr_req(w_wr_req),
        .fpu_start(w_fpu_start), .fpu_op(w_fpu_op), .fpu_a(w_fpu_a), .fpu_b(w_fpu_b),
        .fpu_result(32'h0), .fpu_done(1'b0),
        .ipointer(w_ipointer), .opcode(w_opcode), .flags(w_flags), .halted(w_halted), .debug(w_debug)
    );

    int tests = 0;
    int fails = 0;
    int rd_delay = 0;
    int wr_delay = 2;
    int wait_cnt = 0;
    int wr_hi = 0;
    int start_cnt = 0;
    int fpu_cnt = 0;
    int rd_hi = 0;
    logic        wr_seen = 1'b0;
    logic [15:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;
    logic [31:0] seen_a = '0, seen_b = '0;
    logic [1:0]  seen_op = '0;

    // Program image: {K, R, opcode}
    function automatic logic [31:0] rom(input logic [15:0] a);
        case (a)
            16'h0000: return 32'h0005_0101; // movi r1,5
            16'h0004: return 32'h0001_010A; // add r1,r1 -> 10
            16'h0008: return 32'h0000_011E; // setdebug r1
            16'h000C: return 32'h1234_0201; // movi r2,0x1234
            16'h0010: return 32'h0040_0204; // store [0x40],r2
            16'h0014: return 32'h0001_010C; // cmp r1,r1 -> Z
            16'h0018: return 32'h0020_000F; // jnz 0x20 (not taken)
            16'h001C: return 32'h0030_000E; // jz 0x30 (taken)
            16'h0020, 16'h0024, 16'h0028, 16'h002C: return 32'h0000_001F; // traps
            16'h0030: return 32'h0003_0201; // movi r2,3
            16'h0034: return 32'h0002_010B; // sub r1,r2 -> 7
            16'h0038: return 32'h0001_020C; // cmp r2,r1 -> N
            16'h003C: return 32'h0020_000E; // jz 0x20 (not taken)
            16'h0044: return 32'h0040_0302; // load r3,[0x40]
            16'h0048: return 32'h0000_031E; // setdebug r3
            16'h004C: return 32'h0002_0114; // fadd r1,r2
            16'h0050: return 32'h0000_011E; // setdebug r1
            16'h0054: return 32'h0000_007F; // unknown opcode
            16'h0058: return 32'h0000_001F; // halt
            default:  return 32'h0000_0000;
        endcase
    endfunction

    // RAM responder: reads ack after rd_delay extra cycles, writes after wr_delay.
    always @(negedge clk) begin
        if (!reset && ram_wr_req) wr_hi++;
        if (reset) begin
            ram_ack  = 1'b0;
            wait_cnt = 0;
        end else if (ram_ack) begin
            ram_ack = 1'b0;
        end else if (ram_rd_req || ram_wr_req) begin
            if (wait_cnt < (ram_wr_req ? wr_delay : rd_delay)) begin
                wait_cnt++;
            end else begin
                wait_cnt  = 0;
                ram_ack   = 1'b1;
                ram_rdata = (wr_seen && ram_addr == last_wr_addr) ? last_wr_data : rom(ram_addr);
                if (ram_wr_req) begin
                    wr_seen      = 1'b1;
                    last_wr_addr = ram_addr;
                    last_wr_data = ram_wdata;
                end
            end
        end
    end

    // FPU model: done pulse five cycles after start with a fixed result.
    always @(negedge clk) begin
        if (reset) begin
            fpu_done = 1'b0;
            fpu_cnt  = 0;
        end else begin
            fpu_done = 1'b0;
            if (fpu_start) begin
                start_cnt++;
                fpu_cnt = 5;
                seen_a  = fpu_a;
                seen_b  = fpu_b;
                seen_op = fpu_op;
            end else if (fpu_cnt > 0) begin
                fpu_cnt--;
                if (fpu_cnt == 0) begin
                    fpu_done   = 1'b1;
                    fpu_result = 32'h4040_0000;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset) w_ack = 1'b0;
        else       w_ack = w_rd_req && !w_ack;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ip(input logic [15:0] exp, input string tag);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (ipointer === exp) break;
        end
        check(tag, 32'(ipointer), 32'(exp));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset ip", 32'(ipointer), 32'h0);
        check("reset rd_req", 32'(ram_rd_req), 32'h0);
        check("reset wr_req", 32'(ram_wr_req), 32'h0);
        check("reset halted", 32'(halted), 32'h0);
        check("reset flags", 32'(flags), 32'h0);
        check("reset debug", debug, 32'h0);
        check("reset opcode", 32'(opcode), 32'h0);
        check("reset fpu_start", 32'(fpu_start), 32'h0);
        check("reset wrap ip", 32'(w_ipointer), 32'hFC);

        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("fetch rd_req", 32'(ram_rd_req), 32'h1);
        check("fetch addr", 32'(ram_addr), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("ip after 4 cycles", 32'(ipointer), 32'h4);
        check("wrap ip 0xFC->0", 32'(w_ipointer), 32'h0);
        repeat (4) @(posedge clk);
        #1;
        check("ip after 8 cycles", 32'(ipointer), 32'h8);

        wait_ip(16'h000C, "ip setdebug");
        check("add r1,r1 debug", debug, 32'd10);
        wait_ip(16'h0014, "ip store");
        check("store addr", 32'(last_wr_addr), 32'h40);
        check("store data", last_wr_data, 32'h1234);
        check("store req cycles", 32'(wr_hi), 32'd3);
        wait_ip(16'h0018, "ip cmp");
        check("cmp equal flags", 32'(flags), 32'b01);
        wait_ip(16'h001C, "jnz not taken");
        wait_ip(16'h0030, "jz taken");
        wait_ip(16'h003C, "ip cmp2");
        check("cmp negative flags", 32'(flags), 32'b10);
        wait_ip(16'h0040, "jz not taken");
        wait_ip(16'h0044, "nop op 0x34");
        wait_ip(16'h004C, "ip load");
        check("load debug", debug, 32'h1234);
        wait_ip(16'h0050, "ip fadd");
        check("fpu start pulses", 32'(start_cnt), 32'd1);
        check("fpu_a", seen_a, 32'd7);
        check("fpu_b", seen_b, 32'd3);
        check("fpu_op", 32'(seen_op), 32'd0);
        wait_ip(16'h0054, "ip fadd debug");
        check("fadd result", debug, 32'h4040_0000);
        wait_ip(16'h0058, "nop 0x7F ip");
        check("opcode 0x7F", 32'(opcode), 32'h7F);

        repeat (6) @(posedge clk);
        #1;
        check("halted", 32'(halted), 32'h1);
        rd_hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (ram_rd_req) rd_hi++;
        end
        check("halt no rd_req", 32'(rd_hi), 32'd0);
        check("halt ip frozen", 32'(ipointer), 32'h58);

        @(negedge clk);
        reset = 1'b1;
        rd_delay = 10;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("fwait rd_req", 32'(ram_rd_req), 32'h1);
        check("halt cleared", 32'(halted), 32'h0);
        reset = 1'b1;
        #1;
        check("reset drops rd_req", 32'(ram_rd_req), 32'h0);
        check("reset ip", 32'(ipointer), 32'h0);
        @(negedge clk);
        rd_delay = 0;
        reset = 1'b0;
        wait_ip(16'h0004, "refetch after reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
